// File: rtl/strip_chk_pkg.sv
// Shared types, field widths and expected-frame builder for the strip frame checker.
package strip_chk_pkg;

  localparam int unsigned SEQ_W     = 8;
  localparam int unsigned PAYLOAD_W = 96;
  localparam int unsigned FRAME_W   = 104;
  localparam int unsigned REP_N     = PAYLOAD_W / SEQ_W;

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  typedef enum logic [1:0] {
    StHunt   = HUNT,
    StVerify = VERIFY,
    StLocked = LOCKED,
    StRsvd   = 2'd3
  } chk_state_e;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [SEQ_W-1:0] seq);
    return {seq, {REP_N{~seq}}};
  endfunction

endpackage

// File: rtl/strip_pattern_gen.sv
// Combinational test-pattern generator: sequence number to full expected frame.
module strip_pattern_gen
  import strip_chk_pkg::*;
(
  input  logic [SEQ_W-1:0]   seq_i,
  output logic [FRAME_W-1:0] frame_o
);

  assign frame_o = build_frame(seq_i);

endmodule

// File: rtl/strip_frame_checker.sv
// Strip frame pattern checker with lock FSM and saturating link-quality counters.
// Define STRIP_CHK_ERR_CAPTURE_EN to add first-error capture of received/expected frames.
module strip_frame_checker
  import strip_chk_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic               clk160,
  input  logic               reset_n,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_valid,
  input  logic               clear_cnt,
  output logic               locked,
  output logic [1:0]         state,
  output logic [31:0]        good_cnt,
  output logic [15:0]        err_cnt,
  output logic [7:0]         timeout_cnt,
`ifdef STRIP_CHK_ERR_CAPTURE_EN
  output logic [FRAME_W-1:0] cap_rx,
  output logic [FRAME_W-1:0] cap_exp,
  output logic               cap_valid,
`endif
  output logic               err_pulse
);

  localparam logic [3:0] LockCntV   = 4'(LOCK_CNT);
  localparam logic [3:0] UnlockCntV = 4'(UNLOCK_CNT);
  localparam logic [9:0] TimeoutV   = 10'(TIMEOUT);

  chk_state_e       state_q, state_d;
  logic [SEQ_W-1:0] exp_seq_q, exp_seq_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       bad_q, bad_d;
  logic [9:0]       idle_q, idle_d;
  logic [31:0]      good_q, good_d;
  logic [15:0]      err_q, err_d;
  logic [7:0]       to_q, to_d;
  logic             pulse_q, pulse_d;

  logic [FRAME_W-1:0] rx_exp_frame;
  logic [SEQ_W-1:0]   rx_seq;
  logic               pattern_ok, in_seq;

  assign rx_seq = frame_data[FRAME_W-1 -: SEQ_W];

  strip_pattern_gen u_rx_gen (
    .seq_i   (rx_seq),
    .frame_o (rx_exp_frame)
  );

  assign pattern_ok = (frame_data[PAYLOAD_W-1:0] == rx_exp_frame[PAYLOAD_W-1:0]);
  assign in_seq     = (rx_seq == exp_seq_q);

`ifdef STRIP_CHK_ERR_CAPTURE_EN
  logic [FRAME_W-1:0] exp_frame;
  logic [FRAME_W-1:0] cap_rx_q, cap_rx_d, cap_exp_q, cap_exp_d;
  logic               cap_valid_q, cap_valid_d;

  strip_pattern_gen u_exp_gen (
    .seq_i   (exp_seq_q),
    .frame_o (exp_frame)
  );
`endif

  always_comb begin
    state_d   = state_q;
    exp_seq_d = exp_seq_q;
    run_d     = run_q;
    bad_d     = bad_q;
    idle_d    = '0;
    good_d    = good_q;
    err_d     = err_q;
    to_d      = to_q;
    pulse_d   = 1'b0;
`ifdef STRIP_CHK_ERR_CAPTURE_EN
    cap_rx_d    = cap_rx_q;
    cap_exp_d   = cap_exp_q;
    cap_valid_d = cap_valid_q;
`endif

    case (state_q)
      StHunt: begin
        run_d = '0;
        bad_d = '0;
        if (frame_valid && pattern_ok) begin
          exp_seq_d = rx_seq + 8'd1;
          run_d     = 4'd1;
          state_d   = (LockCntV == 4'd1) ? StLocked : StVerify;
        end
      end
      StVerify: begin
        if (frame_valid) begin
          if (pattern_ok && in_seq) begin
            run_d     = run_q + 4'd1;
            exp_seq_d = exp_seq_q + 8'd1;
            if (run_q + 4'd1 == LockCntV) state_d = StLocked;
          end else begin
            run_d   = '0;
            state_d = StHunt;
          end
        end
      end
      StLocked: begin
        // Timeout takes priority; a frame landing on the timeout cycle is dropped.
        if (idle_q == TimeoutV) begin
          to_d    = (to_q == '1) ? to_q : to_q + 8'd1;
          run_d   = '0;
          bad_d   = '0;
          state_d = StHunt;
        end else if (frame_valid) begin
          if (pattern_ok && in_seq) begin
            good_d    = (good_q == '1) ? good_q : good_q + 32'd1;
            bad_d     = '0;
            exp_seq_d = exp_seq_q + 8'd1;
          end else begin
            err_d     = (err_q == '1) ? err_q : err_q + 16'd1;
            pulse_d   = 1'b1;
            bad_d     = bad_q + 4'd1;
            exp_seq_d = pattern_ok ? rx_seq + 8'd1 : exp_seq_q + 8'd1;
`ifdef STRIP_CHK_ERR_CAPTURE_EN
            if (!cap_valid_q) begin
              cap_rx_d    = frame_data;
              cap_exp_d   = exp_frame;
              cap_valid_d = 1'b1;
            end
`endif
            if (bad_q + 4'd1 == UnlockCntV) begin
              run_d   = '0;
              bad_d   = '0;
              state_d = StHunt;
            end
          end
        end else begin
          idle_d = idle_q + 10'd1;
        end
      end
      default: begin
        run_d   = '0;
        bad_d   = '0;
        state_d = StHunt;
      end
    endcase

    if (clear_cnt) begin
      good_d = '0;
      err_d  = '0;
      to_d   = '0;
`ifdef STRIP_CHK_ERR_CAPTURE_EN
      cap_rx_d    = '0;
      cap_exp_d   = '0;
      cap_valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk160) begin
    if (!reset_n) begin
      state_q   <= StHunt;
      exp_seq_q <= '0;
      run_q     <= '0;
      bad_q     <= '0;
      idle_q    <= '0;
      good_q    <= '0;
      err_q     <= '0;
      to_q      <= '0;
      pulse_q   <= 1'b0;
`ifdef STRIP_CHK_ERR_CAPTURE_EN
      cap_rx_q    <= '0;
      cap_exp_q   <= '0;
      cap_valid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      exp_seq_q <= exp_seq_d;
      run_q     <= run_d;
      bad_q     <= bad_d;
      idle_q    <= idle_d;
      good_q    <= good_d;
      err_q     <= err_d;
      to_q      <= to_d;
      pulse_q   <= pulse_d;
`ifdef STRIP_CHK_ERR_CAPTURE_EN
      cap_rx_q    <= cap_rx_d;
      cap_exp_q   <= cap_exp_d;
      cap_valid_q <= cap_valid_d;
`endif
    end
  end

  assign state       = state_q;
  assign locked      = (state_q == StLocked);
  assign good_cnt    = good_q;
  assign err_cnt     = err_q;
  assign timeout_cnt = to_q;
  assign err_pulse   = pulse_q;
`ifdef STRIP_CHK_ERR_CAPTURE_EN
  assign cap_rx    = cap_rx_q;
  assign cap_exp   = cap_exp_q;
  assign cap_valid = cap_valid_q;
`endif

endmodule
